// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM with one-cycle registered read.
// Drives the memory port, checks read data through a 2-stage compare pipeline, and logs the first failure.
module mbist_march_ctrl #(
   parameter int  WCOUNT  = 256,
   parameter int  WLENGTH = 4,
   localparam int AW      = $clog2(WCOUNT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [AW-1:0]      mem_addr,
   output logic               mem_we,
   output logic [WLENGTH-1:0] mem_din,
   input  logic [WLENGTH-1:0] mem_dout,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [2:0]         fail_elem,
   output logic [AW-1:0]      fail_addr,
   output logic [WLENGTH-1:0] fail_exp,
   output logic [WLENGTH-1:0] fail_got,
   output logic [11:0]        err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] IDX_MAX = AW'(WCOUNT - 1);

   state_t r_state, w_state_nxt;
   logic   r_drain;
   logic   w_accept, w_issue, w_last;

   // Operation currently on the memory port: element, order index, read/write phase
   logic [2:0]    r_elem, w_inc_elem, w_sel_elem;
   logic [AW-1:0] r_idx, w_inc_idx, w_sel_idx;
   logic          r_phase, w_inc_phase, w_sel_phase;

   logic               w_op_we, w_op_bit;
   logic [AW-1:0]      w_op_addr;
   logic [WLENGTH-1:0] w_op_data;

   logic [AW-1:0]      r_mem_addr;
   logic               r_mem_we;
   logic [WLENGTH-1:0] r_mem_din;

   logic               r_p1_valid, r_p2_valid;
   logic [WLENGTH-1:0] r_p1_exp, r_p2_exp;
   logic [AW-1:0]      r_p1_addr, r_p2_addr;
   logic [2:0]         r_p1_elem, r_p2_elem;
   logic               w_mismatch;

   logic               r_fail;
   logic [2:0]         r_fail_elem;
   logic [AW-1:0]      r_fail_addr;
   logic [WLENGTH-1:0] r_fail_exp, r_fail_got;
   logic [11:0]        r_err_cnt;

   assign w_last = (r_elem == 3'd5) && (r_idx == IDX_MAX);

   always_comb begin : p_next_op
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_inc_elem  = r_elem;
      w_inc_idx   = r_idx;
      w_inc_phase = 1'b0;
      if ((r_elem != 3'd0) && (r_elem != 3'd5) && !r_phase) begin
         w_inc_phase = 1'b1;
      end else if (r_idx == IDX_MAX) begin
         w_inc_idx  = '0;
         w_inc_elem = r_elem + 3'd1;
      end else begin
         w_inc_idx = r_idx + AW'(1);
      end
      w_sel_elem  = w_accept ? 3'd0 : w_inc_elem;
      w_sel_idx   = w_accept ? '0   : w_inc_idx;
      w_sel_phase = w_accept ? 1'b0 : w_inc_phase;
   end

   always_comb begin : p_decode
      w_op_we   = 1'b0;
      w_op_bit  = 1'b0;
      w_op_addr = w_sel_idx;
      if ((w_sel_elem == 3'd3) || (w_sel_elem == 3'd4)) w_op_addr = IDX_MAX - w_sel_idx;
      case (w_sel_elem)
         3'd0:       begin w_op_we = 1'b1;        w_op_bit = 1'b0;         end
         3'd1, 3'd3: begin w_op_we = w_sel_phase; w_op_bit = w_sel_phase;  end
         3'd2, 3'd4: begin w_op_we = w_sel_phase; w_op_bit = !w_sel_phase; end
         default:    begin w_op_we = 1'b0;        w_op_bit = 1'b0;         end
      endcase
      w_op_data = {WLENGTH{w_op_bit}};
   end

   always_comb begin : p_fsm
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_accept    = 1'b1;
               w_issue     = 1'b1;
            end
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DRAIN;
            else        w_issue     = 1'b1;
         end
         S_DRAIN: begin
            if (r_drain) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_drain <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= (r_state == S_DRAIN) && !r_drain;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_elem     <= '0;
         r_idx      <= '0;
         r_phase    <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
      end else if (w_issue) begin
         r_elem     <= w_sel_elem;
         r_idx      <= w_sel_idx;
         r_phase    <= w_sel_phase;
         r_mem_we   <= w_op_we;
         r_mem_addr <= w_op_addr;
         r_mem_din  <= w_op_we ? w_op_data : '0;
      end else begin
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
      end
   end

   // Stage 2 lines up with read data returning from the memory
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p1_valid <= 1'b0;
         r_p1_exp   <= '0;
         r_p1_addr  <= '0;
         r_p1_elem  <= '0;
         r_p2_valid <= 1'b0;
         r_p2_exp   <= '0;
         r_p2_addr  <= '0;
         r_p2_elem  <= '0;
      end else begin
         r_p1_valid <= w_issue && !w_op_we;
         r_p1_exp   <= w_op_data;
         r_p1_addr  <= w_op_addr;
         r_p1_elem  <= w_sel_elem;
         r_p2_valid <= r_p1_valid;
         r_p2_exp   <= r_p1_exp;
         r_p2_addr  <= r_p1_addr;
         r_p2_elem  <= r_p1_elem;
      end
   end

   assign w_mismatch = r_p2_valid && (mem_dout != r_p2_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fail      <= 1'b0;
         r_fail_elem <= '0;
         r_fail_addr <= '0;
         r_fail_exp  <= '0;
         r_fail_got  <= '0;
         r_err_cnt   <= '0;
      end else if (w_accept) begin
         r_fail      <= 1'b0;
         r_fail_elem <= '0;
         r_fail_addr <= '0;
         r_fail_exp  <= '0;
         r_fail_got  <= '0;
         r_err_cnt   <= '0;
      end else if (w_mismatch) begin
         if (r_err_cnt != 12'hFFF) r_err_cnt <= r_err_cnt + 12'd1;
         if (!r_fail) begin
            r_fail      <= 1'b1;
            r_fail_elem <= r_p2_elem;
            r_fail_addr <= r_p2_addr;
            r_fail_exp  <= r_p2_exp;
            r_fail_got  <= mem_dout;
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_din   = r_mem_din;
   assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done      = (r_state == S_DONE);
   assign fail      = r_fail;
   assign fail_elem = r_fail_elem;
   assign fail_addr = r_fail_addr;
   assign fail_exp  = r_fail_exp;
   assign fail_got  = r_fail_got;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: SRAM model with an injectable stuck-at bit, and a March C- reference
// built from the element list that predicts every memory operation and the failure log.
module tb_mbist_march_ctrl;

   localparam int WCOUNT  = 256;
   localparam int WLENGTH = 4;
   localparam int AW      = 8;
   localparam int NOPS    = 10 * WCOUNT;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               start = 1'b0;
   logic [AW-1:0]      mem_addr;
   logic               mem_we;
   logic [WLENGTH-1:0] mem_din;
   logic [WLENGTH-1:0] mem_dout;
   logic               busy, done, fail;
   logic [2:0]         fail_elem;
   logic [AW-1:0]      fail_addr;
   logic [WLENGTH-1:0] fail_exp, fail_got;
   logic [11:0]        err_cnt;

   int n_total = 0;
   int n_pass  = 0;

   bit          f_en = 1'b0;
   logic [AW-1:0] f_addr = '0;
   int          f_bit = 0;
   bit          f_val = 1'b0;
   logic [3:0]  f_mask = 4'h1;
   bit          scramble = 1'b0;

   logic [WLENGTH-1:0] mem [WCOUNT];
   logic [WLENGTH-1:0] rd_q;
   logic [AW-1:0]      rd_addr_q;

   typedef struct {
      bit                 we;
      logic [AW-1:0]      addr;
      logic [WLENGTH-1:0] data;
      int                 elem;
   } op_t;
   op_t ops[$];

   bit                 exp_fail;
   int                 exp_cnt, exp_j;
   logic [2:0]         exp_elem;
   logic [AW-1:0]      exp_addr;
   logic [WLENGTH-1:0] exp_exp, exp_got;

   mbist_march_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_elem (fail_elem),
      .fail_addr (fail_addr),
      .fail_exp  (fail_exp),
      .fail_got  (fail_got),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Single-port SRAM: registered read of the sampled address, write visible on the next read
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < WCOUNT; i++) mem[i] <= 4'($urandom);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
      rd_q      <= mem[mem_addr];
      rd_addr_q <= mem_addr;
   end

   assign mem_dout = (f_en && (rd_addr_q == f_addr)) ?
                     (f_val ? (rd_q | f_mask) : (rd_q & ~f_mask)) : rd_q;

   function automatic void push_op(input bit we, input int a, input bit one, input int e);
      op_t o;
      o.we   = we;
      o.addr = AW'(a);
      o.data = one ? 4'hF : 4'h0;
      o.elem = e;
      ops.push_back(o);
   endfunction

   // March C-: 0 up(w0) 1 up(r0,w1) 2 up(r1,w0) 3 down(r0,w1) 4 down(r1,w0) 5 up(r0)
   function automatic void build_ops();
      ops.delete();
      for (int e = 0; e < 6; e++) begin
         for (int n = 0; n < WCOUNT; n++) begin
            int a;
            a = (e == 3 || e == 4) ? (WCOUNT - 1 - n) : n;
            case (e)
               0:       push_op(1'b1, a, 1'b0, e);
               1, 3:    begin push_op(1'b0, a, 1'b0, e); push_op(1'b1, a, 1'b1, e); end
               2, 4:    begin push_op(1'b0, a, 1'b1, e); push_op(1'b1, a, 1'b0, e); end
               default: push_op(1'b0, a, 1'b0, e);
            endcase
         end
      end
   endfunction

   function automatic void predict();
      logic [WLENGTH-1:0] mm [WCOUNT];
      logic [WLENGTH-1:0] got;
      exp_fail = 1'b0;
      exp_cnt  = 0;
      exp_j    = 0;
      exp_elem = '0;
      exp_addr = '0;
      exp_exp  = '0;
      exp_got  = '0;
      for (int j = 0; j < ops.size(); j++) begin
         if (ops[j].we) begin
            mm[ops[j].addr] = ops[j].data;
         end else begin
            got = mm[ops[j].addr];
            if (f_en && ops[j].addr == f_addr) got = f_val ? (got | f_mask) : (got & ~f_mask);
            if (got !== ops[j].data) begin
               exp_cnt++;
               if (!exp_fail) begin
                  exp_fail = 1'b1;
                  exp_j    = j + 1;
                  exp_elem = 3'(ops[j].elem);
                  exp_addr = ops[j].addr;
                  exp_exp  = ops[j].data;
                  exp_got  = got;
               end
            end
         end
      end
   endfunction

   task automatic set_fault(input bit en, input logic [AW-1:0] a, input int b, input bit v);
      f_en   = en;
      f_addr = a;
      f_bit  = b;
      f_val  = v;
      f_mask = 4'b0001 << b;
   endtask

   // One full run: every op, the fail onset cycle, the done latency and the final log are checked
   task automatic do_run(input string tag, input bit noisy);
      int       op_bad = 0, fail_bad = 0, n_wr = 0, n_rd = 0, lat = -1, first_bad = -1;
      logic [12:0] at_start = '1;
      logic     want_fail;
      predict();
      @(negedge clk);
      scramble = 1'b1;
      @(negedge clk);
      scramble = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= NOPS + 10; k++) begin
         @(negedge clk);
         if (k == 1) at_start = {fail, err_cnt};
         want_fail = exp_fail && ((k - 1) >= (exp_j + 1));
         if (fail !== want_fail) fail_bad++;
         if (done === 1'b1) begin
            lat = k - 1;
            if (busy !== 1'b0) op_bad++;
            break;
         end
         if (k <= NOPS) begin
            op_t o;
            o = ops[k - 1];
            if (mem_we !== o.we || mem_addr !== o.addr || (o.we && mem_din !== o.data) || busy !== 1'b1) begin
               op_bad++;
               if (first_bad < 0) first_bad = k;
            end
            if (mem_we === 1'b1) n_wr++;
            else if (mem_we === 1'b0) n_rd++;
         end else if (mem_we !== 1'b0 || mem_addr !== '0 || mem_din !== '0 || busy !== 1'b1) begin
            op_bad++;
            if (first_bad < 0) first_bad = k;
         end
         start = (noisy && k <= NOPS + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start = 1'b0;

      n_total++;
      if (lat != NOPS + 2) $display("FAIL %s/done_latency: got %0d want %0d", tag, lat, NOPS + 2);
      else n_pass++;
      n_total++;
      if (op_bad != 0) $display("FAIL %s/op_sequence: %0d bad cycles, first at op %0d, want 0", tag, op_bad, first_bad);
      else n_pass++;
      n_total++;
      if (at_start !== 13'd0) $display("FAIL %s/clear_on_start: fail,err_cnt=%h want 0", tag, at_start);
      else n_pass++;
      n_total++;
      if (fail_bad != 0) $display("FAIL %s/fail_onset: %0d cycles wrong, want 0 (first mismatch op %0d)", tag, fail_bad, exp_j);
      else n_pass++;
      n_total++;
      if (n_wr != 5 * WCOUNT) $display("FAIL %s/write_count: got %0d want %0d", tag, n_wr, 5 * WCOUNT);
      else n_pass++;
      n_total++;
      if (n_rd != 5 * WCOUNT) $display("FAIL %s/read_count: got %0d want %0d", tag, n_rd, 5 * WCOUNT);
      else n_pass++;
      n_total++;
      if (fail !== exp_fail) $display("FAIL %s/fail: got %b want %b", tag, fail, exp_fail);
      else n_pass++;
      n_total++;
      if (err_cnt !== 12'(exp_cnt)) $display("FAIL %s/err_cnt: got %0d want %0d", tag, err_cnt, exp_cnt);
      else n_pass++;
      n_total++;
      if (fail_elem !== exp_elem) $display("FAIL %s/fail_elem: got %0d want %0d", tag, fail_elem, exp_elem);
      else n_pass++;
      n_total++;
      if (fail_addr !== exp_addr) $display("FAIL %s/fail_addr: got %h want %h", tag, fail_addr, exp_addr);
      else n_pass++;
      n_total++;
      if (fail_exp !== exp_exp) $display("FAIL %s/fail_exp: got %b want %b", tag, fail_exp, exp_exp);
      else n_pass++;
      n_total++;
      if (fail_got !== exp_got) $display("FAIL %s/fail_got: got %b want %b", tag, fail_got, exp_got);
      else n_pass++;
   endtask

   task automatic test_reset();
      int idle_bad = 0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      n_total++;
      if ({mem_we, mem_addr, mem_din, busy, done, fail, fail_elem, fail_addr, fail_exp, fail_got, err_cnt} !== '0)
         $display("FAIL reset/outputs: got we=%b addr=%h din=%h busy=%b done=%b fail=%b err=%0d want all 0",
                  mem_we, mem_addr, mem_din, busy, done, fail, err_cnt);
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
      end
      n_total++;
      if (idle_bad != 0) $display("FAIL reset/idle_hold: %0d active cycles, want 0", idle_bad);
      else n_pass++;
   endtask

   task automatic test_fault_free();
      set_fault(1'b0, '0, 0, 1'b0);
      do_run("fault_free", 1'b0);
   endtask

   task automatic test_stuck_at1();
      set_fault(1'b1, 8'h37, 0, 1'b1);
      do_run("sa1_0x37", 1'b0);
      n_total++;
      if ({fail, fail_elem, fail_addr, fail_exp, fail_got, err_cnt} !== {1'b1, 3'd1, 8'h37, 4'h0, 4'h1, 12'd3})
         $display("FAIL sa1_0x37/log: got fail=%b elem=%0d addr=%h exp=%b got=%b err=%0d want 1,1,37,0000,0001,3",
                  fail, fail_elem, fail_addr, fail_exp, fail_got, err_cnt);
      else n_pass++;
   endtask

   task automatic test_stuck_at0();
      set_fault(1'b1, 8'hC8, 3, 1'b0);
      do_run("sa0_0xc8", 1'b0);
      n_total++;
      if ({fail, fail_elem, fail_addr, fail_exp, fail_got, err_cnt} !== {1'b1, 3'd2, 8'hC8, 4'hF, 4'h7, 12'd2})
         $display("FAIL sa0_0xc8/log: got fail=%b elem=%0d addr=%h exp=%b got=%b err=%0d want 1,2,c8,1111,0111,2",
                  fail, fail_elem, fail_addr, fail_exp, fail_got, err_cnt);
      else n_pass++;
   endtask

   task automatic test_restart_after_fail();
      n_total++;
      if (fail !== 1'b1 || done !== 1'b1) $display("FAIL restart/sticky_in_done: got fail=%b done=%b want 1,1", fail, done);
      else n_pass++;
      set_fault(1'b0, '0, 0, 1'b0);
      do_run("restart", 1'b0);
   endtask

   task automatic test_reset_mid_run();
      int  we_bad = 0;
      logic want_fail;
      set_fault(1'b1, 8'h05, 0, 1'b1);
      predict();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (999) @(negedge clk);
      want_fail = exp_fail && (999 >= exp_j + 1);
      n_total++;
      if (busy !== 1'b1 || fail !== want_fail) $display("FAIL midrun/before_reset: got busy=%b fail=%b want 1,%b", busy, fail, want_fail);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({mem_we, busy, done, fail, err_cnt} !== '0)
         $display("FAIL midrun/async_abort: got we=%b busy=%b done=%b fail=%b err=%0d want 0", mem_we, busy, done, fail, err_cnt);
      else n_pass++;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (mem_we !== 1'b0) we_bad++;
      end
      n_total++;
      if (we_bad != 0) $display("FAIL midrun/writes_in_reset: %0d cycles with mem_we, want 0", we_bad);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      set_fault(1'b0, '0, 0, 1'b0);
      do_run("after_reset", 1'b0);
   endtask

   task automatic test_start_ignored();
      set_fault(1'b0, '0, 0, 1'b0);
      do_run("noisy_start", 1'b1);
   endtask

   task automatic test_random_faults();
      for (int r = 0; r < 3; r++) begin
         set_fault(1'b1, AW'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         do_run($sformatf("random%0d", r), r == 2);
      end
   endtask

   initial begin
      build_ops();
      test_reset();
      test_fault_free();
      test_stuck_at1();
      test_stuck_at0();
      test_restart_after_fail();
      test_reset_mid_run();
      test_start_ignored();
      test_random_faults();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_total);
      $fatal(1);
   end

endmodule
